branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
// Dynamic branch predictor: direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters,
// optional gshare indexing. Sits beside the IF stage: IF pc looked up combinationally, next fetch pc chosen the
// same cycle; EX-stage branch resolution written back as updates. Replaces static not-taken fetch; also counts
// resolved branches and mispredicts for CoreMark profiling.
// PARAMETERS
// XLEN     32  address/target width
// IDX_W    6   log2(entries); ENTRIES = 2**IDX_W
// TAG_W    10  tag bits taken from pc[IDX_W+TAG_W+1 : IDX_W+2]
// MODE     0   0 = bimodal (index = pc[IDX_W+1:2]); 1 = gshare (index = pc[IDX_W+1:2] ^ GHR)
// GHIST_W  6   global history width, 1..IDX_W; GHR zero-extended to IDX_W for the XOR; unused when MODE=0
// PORTS
// clk             in   1        system clock, all state on posedge
// rst             in   1        synchronous active-high reset
// pred_pc_i       in   XLEN     IF-stage fetch pc (lookup)
// pred_hit_o      out  1        valid BTB entry with matching tag
// pred_taken_o    out  1        predicted taken
// pred_target_o   out  XLEN     predicted next pc (stored target if taken, else pred_pc_i+4)
// pred_ghr_o      out  GHIST_W  GHR used for this lookup; pipeline carries it to EX
// upd_valid_i     in   1        one resolved control-transfer instruction this cycle
// upd_pc_i        in   XLEN     pc of resolved instruction
// upd_is_cond_i   in   1        1 = conditional branch, 0 = JAL/JALR
// upd_taken_i     in   1        actual direction
// upd_target_i    in   XLEN     actual target (valid when taken)
// upd_ghr_i       in   GHIST_W  GHR snapshot carried with the instruction
// upd_mispred_i   in   1        predicted next pc differed from actual next pc
// cnt_branch_o    out  32       resolved-update count
// cnt_mispred_o   out  32       mispredict count
// BEHAVIOUR
// - Entry = {valid, tag[TAG_W], target[XLEN], ctr[2], is_jump}; flop array, asynchronous read.
// - Lookup, 0-cycle latency: idx from pred_pc_i (+ current GHR in MODE 1); hit = valid && tag match;
//   taken = hit && (is_jump || ctr[1]); target = taken ? entry.target : pred_pc_i + 4 (wraps mod 2**XLEN).
// - Update, effective next posedge, only when upd_valid_i && !rst; idx from upd_pc_i (+ upd_ghr_i in MODE 1):
//   * tag hit, cond: ctr saturating +1 if taken (max 2'b11), -1 if not (min 2'b00); target <= upd_target_i if taken.
//   * tag hit, jump: ctr <= 2'b11, is_jump <= 1, target <= upd_target_i.
//   * miss and taken: allocate/overwrite: valid=1, new tag, target, is_jump=!upd_is_cond_i,
//     ctr = cond ? 2'b10 (weak taken) : 2'b11.
//   * miss and not taken: no change (no allocation).
// - GHR (MODE 1): on upd_valid_i && upd_is_cond_i, GHR <= {GHR[GHIST_W-2:0], upd_taken_i}; non-speculative.
//   MODE 0: GHR held at 0, pred_ghr_o = 0.
// - Same cycle lookup and update of the same entry: lookup returns pre-update contents, no bypass.
// - Counters: cnt_branch_o +1 per upd_valid_i; cnt_mispred_o +1 when upd_valid_i && upd_mispred_i;
//   both saturate at 32'hFFFF_FFFF, no wrap.
// - Reset (any cycle, incl. during an update): all valid, ctr, is_jump, GHR and counters cleared next posedge;
//   a concurrent update is discarded. Outputs after reset: hit=0, taken=0, target=pc+4, ghr=0, counts=0.
// - No internal handshake/backpressure; at most one update per cycle.
// TESTING (IDX_W=4, TAG_W=8, MODE=0 unless stated)
// 1 Reset, lookup pc=0x8000 -> hit=0, taken=0, target=0x8004, cnt_branch=0.
// 2 Update 0x8010 cond taken tgt 0x8000; lookup 0x8010 next cycle -> hit=1, taken=1, target=0x8000 (ctr=10);
//   same-cycle lookup -> hit=0.
// 3 On that entry: 2x not-taken -> ctr 00, taken=0, target=0x8014; 4x taken -> ctr 11; 1x not-taken -> ctr 10, taken=1.
// 4 Alias: taken update 0x8050 (idx 4, tag 0x01) replaces 0x8010 entry -> lookup 0x8010 hit=0, 0x8050 hit=1.
//   Not-taken update of 0x8090 on empty idx 4 after reset -> no allocation.
// 5 Jump update 0x8020 tgt 0x9000 -> taken=1, target=0x9000; later cond not-taken update to it -> ctr 10, still taken.
// 6 MODE=1, GHIST_W=4: 1 taken cond update (GHR=0001); update 0x8000 taken with upd_ghr=0001 -> lookup 0x8000
//   hits only while GHR=0001; rst asserted with upd_valid -> entry not written, counters 0; force counters to
//   0xFFFF_FFFF -> remain saturated.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit saturating direction counters,
//               bimodal or gshare indexing, zero-latency lookup for IF and
//               EX-stage update port, plus saturating profiling counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 10,
    parameter int MODE    = 0,
    parameter int GHIST_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pred_pc_i,
    output logic               pred_hit_o,
    output logic               pred_taken_o,
    output logic [XLEN-1:0]    pred_target_o,
    output logic [GHIST_W-1:0] pred_ghr_o,
    input  logic               upd_valid_i,
    input  logic [XLEN-1:0]    upd_pc_i,
    input  logic               upd_is_cond_i,
    input  logic               upd_taken_i,
    input  logic [XLEN-1:0]    upd_target_i,
    input  logic [GHIST_W-1:0] upd_ghr_i,
    input  logic               upd_mispred_i,
    output logic [31:0]        cnt_branch_o,
    output logic [31:0]        cnt_mispred_o
);

    localparam int         C_ENTRIES = 1 << IDX_W;
    localparam logic [1:0] C_CTR_MAX = 2'b11;
    localparam logic [1:0] C_CTR_MIN = 2'b00;
    localparam logic [1:0] C_CTR_WT  = 2'b10;

    // Entry storage: control bits are reset, payload (tag/target) is not
    logic             r_valid  [C_ENTRIES];
    logic [1:0]       r_ctr    [C_ENTRIES];
    logic             r_jump   [C_ENTRIES];
    logic [TAG_W-1:0] r_tag    [C_ENTRIES];
    logic [XLEN-1:0]  r_target [C_ENTRIES];

    logic [31:0]        r_cnt_branch;
    logic [31:0]        r_cnt_mispred;
    logic [GHIST_W-1:0] w_ghr;

    logic [IDX_W-1:0] w_pidx;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_ptag;
    logic [TAG_W-1:0] w_utag;
    logic             w_p_hit;
    logic             w_u_hit;
    logic             w_alloc;
    logic             w_wr_target;
    logic             w_unused_bits;

    assign w_ptag = pred_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_utag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Address bits outside index/tag fields are intentionally ignored
    assign w_unused_bits = ^{pred_pc_i, upd_pc_i, upd_ghr_i};

    generate
        if (MODE == 1) begin : g_gshare
            logic [GHIST_W-1:0] r_ghr;

            // Non-speculative history: shifts only on resolved conditional branches
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (upd_valid_i && upd_is_cond_i) begin
                    r_ghr <= GHIST_W'({r_ghr, upd_taken_i});
                end
            end

            assign w_ghr  = r_ghr;
            assign w_pidx = pred_pc_i[IDX_W+1:2] ^ IDX_W'(r_ghr);
            assign w_uidx = upd_pc_i[IDX_W+1:2] ^ IDX_W'(upd_ghr_i);
        end else begin : g_bimodal
            assign w_ghr  = '0;
            assign w_pidx = pred_pc_i[IDX_W+1:2];
            assign w_uidx = upd_pc_i[IDX_W+1:2];
        end
    endgenerate

    // Lookup path: pure combinational read, sees pre-update contents
    assign w_p_hit       = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
    assign pred_hit_o    = w_p_hit;
    assign pred_taken_o  = w_p_hit && (r_jump[w_pidx] || r_ctr[w_pidx][1]);
    assign pred_target_o = pred_taken_o ? r_target[w_pidx] : (pred_pc_i + XLEN'(4));
    assign pred_ghr_o    = w_ghr;

    // Update decode
    assign w_u_hit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_alloc     = upd_valid_i && !rst && !w_u_hit && upd_taken_i;
    assign w_wr_target = upd_valid_i && !rst &&
                         (w_u_hit ? (upd_taken_i || !upd_is_cond_i) : upd_taken_i);

    // Control bits: valid, direction counter and jump flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b00;
                r_jump[i]  <= 1'b0;
            end
        end else if (upd_valid_i) begin
            if (w_u_hit) begin
                if (upd_is_cond_i) begin
                    if (upd_taken_i) begin
                        if (r_ctr[w_uidx] != C_CTR_MAX) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
                    end else begin
                        if (r_ctr[w_uidx] != C_CTR_MIN) r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
                    end
                end else begin
                    r_ctr[w_uidx]  <= C_CTR_MAX;
                    r_jump[w_uidx] <= 1'b1;
                end
            end else if (upd_taken_i) begin
                r_valid[w_uidx] <= 1'b1;
                r_jump[w_uidx]  <= !upd_is_cond_i;
                r_ctr[w_uidx]   <= upd_is_cond_i ? C_CTR_WT : C_CTR_MAX;
            end
        end
    end

    // Payload: tag on allocation, target whenever a taken outcome is recorded
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_uidx] <= w_utag;
        end
        if (w_wr_target) begin
            r_target[w_uidx] <= upd_target_i;
        end
    end

    // Profiling counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else if (upd_valid_i) begin
            if (r_cnt_branch != 32'hFFFF_FFFF) begin
                r_cnt_branch <= r_cnt_branch + 32'd1;
            end
            if (upd_mispred_i && (r_cnt_mispred != 32'hFFFF_FFFF)) begin
                r_cnt_mispred <= r_cnt_mispred + 32'd1;
            end
        end
    end

    assign cnt_branch_o  = r_cnt_branch;
    assign cnt_mispred_o = r_cnt_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench; one bimodal and one gshare
//               instance share the lookup/update stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst1;
    logic [31:0] pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [3:0]  upd_ghr;
    logic        upd_mispred;

    logic        hit0, taken0, hit1, taken1;
    logic [31:0] target0, target1;
    logic [3:0]  ghr0, ghr1;
    logic [31:0] cb0, cm0, cb1, cm1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .IDX_W(4), .TAG_W(8), .MODE(0), .GHIST_W(4)) dut0 (
        .clk(clk), .rst(rst0), .pred_pc_i(pc),
        .pred_hit_o(hit0), .pred_taken_o(taken0), .pred_target_o(target0), .pred_ghr_o(ghr0),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_cond_i(upd_is_cond),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_ghr_i(upd_ghr),
        .upd_mispred_i(upd_mispred), .cnt_branch_o(cb0), .cnt_mispred_o(cm0)
    );

    branch_predictor #(.XLEN(32), .IDX_W(4), .TAG_W(8), .MODE(1), .GHIST_W(4)) dut1 (
        .clk(clk), .rst(rst1), .pred_pc_i(pc),
        .pred_hit_o(hit1), .pred_taken_o(taken1), .pred_target_o(target1), .pred_ghr_o(ghr1),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_cond_i(upd_is_cond),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_ghr_i(upd_ghr),
        .upd_mispred_i(upd_mispred), .cnt_branch_o(cb1), .cnt_mispred_o(cm1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] a);
        pc = a;
        #1;
    endtask

    // One resolved update, visible to lookups after the task returns
    task automatic upd(input logic [31:0] a, input logic cond, input logic tk,
                       input logic [31:0] tgt, input logic [3:0] gh, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = a;
        upd_is_cond = cond;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_ghr     = gh;
        upd_mispred = mp;
        tick();
        upd_valid   = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; pc = 32'h0;
        upd_valid = 1'b0; upd_pc = '0; upd_is_cond = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_ghr = '0; upd_mispred = 1'b0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset state
        look(32'h8000);
        check("rst_hit",    {31'd0, hit0},   32'd0);
        check("rst_taken",  {31'd0, taken0}, 32'd0);
        check("rst_target", target0,         32'h8004);
        check("rst_cntb",   cb0,             32'd0);
        check("rst_ghr1",   {28'd0, ghr1},   32'd0);

        // Allocation; same-cycle lookup sees old contents
        upd_valid = 1'b1; upd_pc = 32'h8010; upd_is_cond = 1'b1; upd_taken = 1'b1;
        upd_target = 32'h8000; upd_ghr = 4'h0; upd_mispred = 1'b1;
        look(32'h8010);
        check("same_cycle_hit", {31'd0, hit0}, 32'd0);
        tick();
        upd_valid = 1'b0;
        look(32'h8010);
        check("alloc_hit",    {31'd0, hit0},   32'd1);
        check("alloc_taken",  {31'd0, taken0}, 32'd1);
        check("alloc_target", target0,         32'h8000);

        // Counter walk: 10 -> 01 -> 00 -> 00 (sat) -> 01 -> 10 -> 11 -> 11 -> 10
        upd(32'h8010, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        look(32'h8010);
        check("ctr01_taken",  {31'd0, taken0}, 32'd0);
        check("ctr01_target", target0,         32'h8014);
        upd(32'h8010, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        upd(32'h8010, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        upd(32'h8010, 1'b1, 1'b1, 32'h8000, 4'h0, 1'b0);
        look(32'h8010);
        check("ctr_minsat_taken", {31'd0, taken0}, 32'd0);
        upd(32'h8010, 1'b1, 1'b1, 32'h8000, 4'h0, 1'b0);
        look(32'h8010);
        check("ctr10_taken", {31'd0, taken0}, 32'd1);
        upd(32'h8010, 1'b1, 1'b1, 32'h8000, 4'h0, 1'b0);
        upd(32'h8010, 1'b1, 1'b1, 32'h8000, 4'h0, 1'b0);
        upd(32'h8010, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        look(32'h8010);
        check("ctr_maxsat_taken",  {31'd0, taken0}, 32'd1);
        check("ctr_maxsat_target", target0,         32'h8000);

        // Alias replacement at index 4
        upd(32'h8050, 1'b1, 1'b1, 32'h8100, 4'h0, 1'b1);
        look(32'h8010);
        check("alias_old_hit", {31'd0, hit0}, 32'd0);
        look(32'h8050);
        check("alias_new_hit",    {31'd0, hit0}, 32'd1);
        check("alias_new_target", target0,       32'h8100);
        check("cnt_branch_10", cb0, 32'd10);
        check("cnt_mispred_2", cm0, 32'd2);

        // Reset clears entries and counters; not-taken miss does not allocate
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        look(32'h8050);
        check("post_rst_hit",  {31'd0, hit0}, 32'd0);
        check("post_rst_cntb", cb0,           32'd0);
        upd(32'h8090, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        look(32'h8090);
        check("nt_no_alloc", {31'd0, hit0}, 32'd0);

        // Jump entries stay taken regardless of later conditional updates
        upd(32'h8020, 1'b0, 1'b1, 32'h9000, 4'h0, 1'b1);
        look(32'h8020);
        check("jump_taken",  {31'd0, taken0}, 32'd1);
        check("jump_target", target0,         32'h9000);
        upd(32'h8020, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        upd(32'h8020, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        look(32'h8020);
        check("jump_nt_taken",  {31'd0, taken0}, 32'd1);
        check("jump_nt_target", target0,         32'h9000);
        check("cnt_branch_4",  cb0, 32'd4);
        check("cnt_mispred_1", cm0, 32'd1);

        // Fall-through wraps modulo 2**32
        look(32'hFFFF_FFFC);
        check("wrap_target", target0, 32'h0);

        // gshare instance
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        upd(32'h8040, 1'b1, 1'b1, 32'h8200, 4'h0, 1'b0);
        look(32'h8000);
        check("gs_ghr_0001", {28'd0, ghr1}, 32'd1);
        check("bm_ghr_zero", {28'd0, ghr0}, 32'd0);
        upd(32'h8000, 1'b0, 1'b1, 32'h8300, 4'h1, 1'b0);
        look(32'h8000);
        check("gs_hit_ghr1",    {31'd0, hit1}, 32'd1);
        check("gs_target_ghr1", target1,       32'h8300);
        upd(32'h80C0, 1'b1, 1'b0, 32'h0, 4'h1, 1'b0);
        look(32'h8000);
        check("gs_ghr_0010",   {28'd0, ghr1}, 32'd2);
        check("gs_miss_ghr2",  {31'd0, hit1}, 32'd0);
        check("gs_cnt_branch", cb1,           32'd3);

        // Reset concurrent with an update discards the update
        rst1 = 1'b1;
        upd(32'h8000, 1'b0, 1'b1, 32'h8400, 4'h0, 1'b1);
        rst1 = 1'b0;
        look(32'h8000);
        check("rst_upd_hit",  {31'd0, hit1}, 32'd0);
        check("rst_upd_cntb", cb1,           32'd0);
        check("rst_upd_cntm", cm1,           32'd0);
        check("rst_upd_ghr",  {28'd0, ghr1}, 32'd0);

        // Counter saturation
        dut0.r_cnt_branch  = 32'hFFFF_FFFE;
        dut0.r_cnt_mispred = 32'hFFFF_FFFF;
        upd(32'h8100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1);
        #1;
        check("sat_cntb_reach", cb0, 32'hFFFF_FFFF);
        check("sat_cntm_hold",  cm0, 32'hFFFF_FFFF);
        upd(32'h8100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1);
        #1;
        check("sat_cntb_hold", cb0, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
